// File: rtl/scan_serdes_if.sv
// Scan port bundle: serial si/so streams, parallel core scan words and controller gating.
// slave is the serdes view, master is the chip-side and core-side view.
interface scan_serdes_if #(
  parameter int DATA_W = 128,
  parameter int SER_W  = 1
);
  logic              enable_scan_in;
  logic              enable_scan_out;
  logic [SER_W-1:0]  si_data;
  logic              si_valid;
  logic              si_ready;
  logic [DATA_W-1:0] scan_in_bus;
  logic              scan_in_load;
  logic [DATA_W-1:0] scan_out_bus;
  logic              capture;
  logic [SER_W-1:0]  so_data;
  logic              so_valid;
  logic              so_ready;
  logic              busy;
  logic              conflict;

  modport slave (
    input  enable_scan_in, enable_scan_out, si_data, si_valid, scan_out_bus, capture, so_ready,
    output si_ready, scan_in_bus, scan_in_load, so_data, so_valid, busy, conflict
  );

  modport master (
    output enable_scan_in, enable_scan_out, si_data, si_valid, scan_out_bus, capture, so_ready,
    input  si_ready, scan_in_bus, scan_in_load, so_data, so_valid, busy, conflict
  );
endinterface

// File: rtl/scan_serdes.sv
// Serial<->parallel scan bridge: scan_in_load/scan_in_bus one cycle after the last si beat.
// si stalls on si_valid low, so holds on so_ready low; dropping the active enable aborts.
module scan_serdes #(
  parameter int DATA_W = 128,
  parameter int SER_W  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  scan_serdes_if.slave  sif
);
  localparam int BEATS = DATA_W / SER_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] LOAD      = 3'd2;
  localparam logic [2:0] CAPTURE   = 3'd3;
  localparam logic [2:0] SHIFT_OUT = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] capreg;
  logic [DATA_W-1:0] in_bus;
  logic [DATA_W-1:0] shreg_nxt;
  logic              conflict_q;
  logic              en_in;
  logic              en_out;
  logic              si_fire;
  logic              so_fire;
  logic              last_beat;

  assign en_in     = sif.enable_scan_in;
  assign en_out    = sif.enable_scan_out;
  assign si_fire   = sif.si_valid & sif.si_ready;
  assign so_fire   = sif.so_valid & sif.so_ready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign shreg_nxt = (shreg << SER_W) | DATA_W'(sif.si_data);

  // si_ready is gated by reset so the pin drops immediately, not just after the state clears;
  // it is also withheld while both enables are high so no beat is accepted into an abort.
  assign sif.si_ready     = ~reset_n & en_in & ~en_out & ((state == IDLE) | (state == SHIFT_IN));
  assign sif.so_valid     = (state == SHIFT_OUT);
  assign sif.so_data      = sif.so_valid ? capreg[DATA_W-1 -: SER_W] : '0;
  assign sif.scan_in_load = (state == LOAD);
  assign sif.scan_in_bus  = in_bus;
  assign sif.busy         = (state != IDLE);
  assign sif.conflict     = conflict_q;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      capreg     <= '0;
      in_bus     <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (en_in & en_out)
        conflict_q <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (si_fire) begin
            shreg <= shreg_nxt;
            if (last_beat) begin
              in_bus <= shreg_nxt;
              state  <= LOAD;
            end else begin
              cnt   <= CNT_W'(1);
              state <= SHIFT_IN;
            end
          end else if (sif.capture & en_out & ~en_in) begin
            state <= CAPTURE;
          end
        end

        SHIFT_IN: begin
          if (~en_in | en_out) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (si_fire) begin
            shreg <= shreg_nxt;
            // Holding register is written on the final beat so it is valid during LOAD.
            if (last_beat) begin
              in_bus <= shreg_nxt;
              cnt    <= '0;
              state  <= LOAD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        LOAD: begin
          cnt   <= '0;
          state <= IDLE;
        end

        CAPTURE: begin
          capreg <= sif.scan_out_bus;
          cnt    <= '0;
          state  <= SHIFT_OUT;
        end

        SHIFT_OUT: begin
          if (~en_out | en_in) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (so_fire) begin
            capreg <= capreg << SER_W;
            if (last_beat) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_serdes.sv
// Directed bench for scan_serdes: shift-in, stalls, shift-out, aborts, conflict and async reset.
module tb_scan_serdes;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   load_cnt;
  logic [127:0] w1;
  logic [127:0] w2;

  scan_serdes_if #(.DATA_W(128), .SER_W(1)) sif ();

  scan_serdes #(.DATA_W(128), .SER_W(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sif.scan_in_load) load_cnt = load_cnt + 1;

  task automatic test_reset();
    reset_n = 1'b1;
    sif.enable_scan_in = 1'b1;
    #2;
    n_cmp++;
    if ({sif.busy, sif.si_ready, sif.scan_in_load, sif.so_valid, sif.conflict, sif.so_data} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000",
               {sif.busy, sif.si_ready, sif.scan_in_load, sif.so_valid, sif.conflict, sif.so_data});
    end
    n_cmp++;
    if (sif.scan_in_bus !== 128'h0) begin
      n_err++;
      $display("FAIL reset_bus: got %h want 0", sif.scan_in_bus);
    end
    @(negedge clk);
    reset_n = 1'b0;
    sif.enable_scan_in = 1'b0;
    #1;
    n_cmp++;
    if (sif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_busy: got %b want 0", sif.busy);
    end
  endtask

  task automatic test_abort_in();
    int miss;
    miss = 0;
    sif.enable_scan_in  = 1'b1;
    sif.enable_scan_out = 1'b0;
    for (int b = 0; b < 64; b++) begin
      @(negedge clk);
      sif.si_valid = 1'b1;
      sif.si_data  = w1[127-b];
      #1;
      if (sif.si_ready !== 1'b1) miss++;
    end
    @(negedge clk);
    sif.si_valid = 1'b0;
    sif.enable_scan_in = 1'b0;
    #1;
    n_cmp++;
    if (miss !== 0) begin
      n_err++;
      $display("FAIL abort_ready: %0d beats refused, want 0", miss);
    end
    n_cmp++;
    if (sif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_busy_mid: got %b want 1", sif.busy);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (sif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: busy got %b want 0", sif.busy);
    end
    n_cmp++;
    if (sif.scan_in_bus !== 128'h0) begin
      n_err++;
      $display("FAIL abort_bus: got %h want 0", sif.scan_in_bus);
    end
    n_cmp++;
    if (load_cnt !== 0) begin
      n_err++;
      $display("FAIL abort_load: %0d load pulses, want 0", load_cnt);
    end
  endtask

  task automatic test_shift_in(input logic [127:0] w, input int sa, input int sb,
                               input int exp_cyc, input string tag);
    int cyc;
    int miss;
    int base;
    cyc  = 0;
    miss = 0;
    base = load_cnt;
    sif.enable_scan_in  = 1'b1;
    sif.enable_scan_out = 1'b0;
    for (int b = 0; b < 128; b++) begin
      if (b == sa || b == sb) begin
        repeat (5) begin
          @(negedge clk);
          sif.si_valid = 1'b0;
          cyc++;
        end
      end
      @(negedge clk);
      sif.si_valid = 1'b1;
      sif.si_data  = w[127-b];
      cyc++;
      #1;
      if (sif.si_ready !== 1'b1) miss++;
    end
    @(negedge clk);
    cyc++;
    #1;
    n_cmp++;
    if (miss !== 0) begin
      n_err++;
      $display("FAIL %s_ready: %0d beats refused, want 0", tag, miss);
    end
    n_cmp++;
    if (sif.scan_in_load !== 1'b1 || cyc !== exp_cyc) begin
      n_err++;
      $display("FAIL %s_load_timing: load=%b at cycle %0d, want 1 at %0d", tag, sif.scan_in_load, cyc, exp_cyc);
    end
    n_cmp++;
    if (sif.scan_in_bus !== w) begin
      n_err++;
      $display("FAIL %s_bus: got %h want %h", tag, sif.scan_in_bus, w);
    end
    n_cmp++;
    if (sif.si_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ready_in_load: got %b want 0", tag, sif.si_ready);
    end
    sif.si_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (sif.busy !== 1'b0 || sif.scan_in_load !== 1'b0) begin
      n_err++;
      $display("FAIL %s_after: busy=%b load=%b want 0 0", tag, sif.busy, sif.scan_in_load);
    end
    n_cmp++;
    if (load_cnt - base !== 1) begin
      n_err++;
      $display("FAIL %s_pulses: got %0d want 1", tag, load_cnt - base);
    end
  endtask

  task automatic test_shift_out(input logic [127:0] w);
    logic [127:0] got;
    logic held;
    bit   have_hold;
    int   n;
    int   t;
    int   vld_miss;
    int   hold_err;
    got = '0;
    n = 0; t = 0; vld_miss = 0; hold_err = 0; have_hold = 0; held = 0;
    sif.enable_scan_in  = 1'b0;
    sif.enable_scan_out = 1'b1;
    @(negedge clk);
    sif.scan_out_bus = w;
    sif.capture = 1'b1;
    @(negedge clk);
    sif.capture = 1'b0;
    #1;
    n_cmp++;
    if (sif.busy !== 1'b1 || sif.so_valid !== 1'b0) begin
      n_err++;
      $display("FAIL capture_state: busy=%b so_valid=%b want 1 0", sif.busy, sif.so_valid);
    end
    while (n < 128 && t < 600) begin
      @(negedge clk);
      sif.so_ready = (t % 2 == 0);
      #1;
      if (sif.so_valid !== 1'b1) vld_miss++;
      else begin
        if (have_hold && sif.so_data !== held) hold_err++;
        if (sif.so_ready) begin
          got = {got[126:0], sif.so_data[0]};
          n++;
        end
        have_hold = !sif.so_ready;
        held = sif.so_data[0];
      end
      t++;
    end
    @(negedge clk);
    sif.so_ready = 1'b0;
    #1;
    n_cmp++;
    if (n !== 128) begin
      n_err++;
      $display("FAIL so_beats: got %0d want 128", n);
    end
    n_cmp++;
    if (got !== w) begin
      n_err++;
      $display("FAIL so_word: got %h want %h", got, w);
    end
    n_cmp++;
    if (vld_miss !== 0 || hold_err !== 0) begin
      n_err++;
      $display("FAIL so_valid_hold: valid gaps %0d hold changes %0d want 0 0", vld_miss, hold_err);
    end
    n_cmp++;
    if (sif.so_valid !== 1'b0 || sif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL so_end: so_valid=%b busy=%b want 0 0", sif.so_valid, sif.busy);
    end
    sif.enable_scan_out = 1'b0;
  endtask

  task automatic test_conflict();
    sif.enable_scan_out = 1'b1;
    sif.scan_out_bus = w2;
    @(negedge clk);
    sif.capture = 1'b1;
    @(negedge clk);
    sif.capture = 1'b0;
    sif.so_ready = 1'b1;
    repeat (5) @(negedge clk);
    sif.enable_scan_in = 1'b1;
    #1;
    n_cmp++;
    if (sif.conflict !== 1'b0 || sif.so_valid !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_pre: conflict=%b so_valid=%b want 0 1", sif.conflict, sif.so_valid);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (sif.conflict !== 1'b1 || sif.so_valid !== 1'b0 || sif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_abort: conflict=%b so_valid=%b busy=%b want 1 0 0",
               sif.conflict, sif.so_valid, sif.busy);
    end
    n_cmp++;
    if (sif.si_ready !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_si_ready: got %b want 0", sif.si_ready);
    end
    sif.enable_scan_in = 1'b0;
    sif.so_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sif.conflict !== 1'b1 || sif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_sticky: conflict=%b busy=%b want 1 0", sif.conflict, sif.busy);
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (sif.conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_clear: got %b want 0", sif.conflict);
    end
    #1;
    reset_n = 1'b0;
    sif.enable_scan_out = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    base = load_cnt;
    sif.enable_scan_in  = 1'b1;
    sif.enable_scan_out = 1'b0;
    for (int b = 0; b < 50; b++) begin
      @(negedge clk);
      sif.si_valid = 1'b1;
      sif.si_data  = w2[127-b];
      #1;
    end
    #1;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({sif.busy, sif.si_ready, sif.scan_in_load, sif.so_valid, sif.conflict} !== 5'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b want 00000",
               {sif.busy, sif.si_ready, sif.scan_in_load, sif.so_valid, sif.conflict});
    end
    n_cmp++;
    if (sif.scan_in_bus !== 128'h0) begin
      n_err++;
      $display("FAIL midreset_bus: got %h want 0", sif.scan_in_bus);
    end
    #1;
    reset_n = 1'b0;
    sif.si_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (sif.busy !== 1'b0 || sif.si_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_idle: busy=%b si_ready=%b want 0 1", sif.busy, sif.si_ready);
    end
    n_cmp++;
    if (load_cnt !== base) begin
      n_err++;
      $display("FAIL midreset_load: %0d pulses, want 0", load_cnt - base);
    end
    sif.enable_scan_in = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b1;
    n_cmp = 0;
    n_err = 0;
    load_cnt = 0;
    w1 = 128'h000102030405060708090A0B0C0D0E0F;
    w2 = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
    sif.enable_scan_in  = 1'b0;
    sif.enable_scan_out = 1'b0;
    sif.si_data  = '0;
    sif.si_valid = 1'b0;
    sif.scan_out_bus = '0;
    sif.capture  = 1'b0;
    sif.so_ready = 1'b0;

    test_reset();
    test_abort_in();
    test_shift_in(w1, -1, -1, 129, "shift_in");
    test_shift_in(w1, 10, 100, 139, "stall_in");
    test_shift_out(w2);
    test_conflict();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/scan_serdes.md
Name: scan_serdes

Overview:
- Serial scan access port in front of the AES core's parallel scan interface.
- Deserialises an external scan-in stream into the 128-bit ScanIn word, loaded into the core under the test controller's enableScanIn.
- Captures the core's 128-bit ScanOut word under enableScanOut and serialises it back out.
- Sits between the chip-level scan pins and aes_core; the controller's gating signals are the only authority for transfers in either direction.

Parameters:
- DATA_W, 128, width of the parallel scan word.
- SER_W, 1, serial bits per beat. DATA_W must be an integer multiple of SER_W.
- BEATS, DATA_W/SER_W, beats per word (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-high reset; clears all state immediately when high.
- enable_scan_in  input  1  from test controller; permits shift-in.
- enable_scan_out  input  1  from test controller; permits capture/shift-out.
- si_data  input  SER_W  serial scan-in data, MSB-first.
- si_valid  input  1  si_data beat valid.
- si_ready  output  1  port accepts a si beat this cycle.
- scan_in_bus  output  DATA_W  assembled word to core ScanIn; holding register.
- scan_in_load  output  1  one-cycle pulse: scan_in_bus newly updated.
- scan_out_bus  input  DATA_W  core ScanOut.
- capture  input  1  request to snapshot scan_out_bus.
- so_data  output  SER_W  serial scan-out data, MSB-first.
- so_valid  output  1  so_data beat valid.
- so_ready  input  1  downstream accepts so beat.
- busy  output  1  FSM not in IDLE.
- conflict  output  1  sticky: both enables seen high together.

Behaviour:
- Reset values: all outputs 0; scan_in_bus=0; shift/capture registers=0; beat counter=0; FSM=IDLE; conflict=0.
- FSM states: IDLE, SHIFT_IN, LOAD, CAPTURE, SHIFT_OUT.
- IDLE:
  - si_ready = enable_scan_in & ~enable_scan_out.
  - First accepted beat (si_valid & si_ready) shifts in and moves to SHIFT_IN with counter=1.
  - Else capture & enable_scan_out & ~enable_scan_in moves to CAPTURE.
  - Shift-in takes priority; capture is ignored while a beat is accepted.
- SHIFT_IN:
  - si_ready = enable_scan_in.
  - Each accepted beat: shreg <= {shreg[DATA_W-SER_W-1:0], si_data}; counter++.
  - si_valid low stalls without loss.
  - The beat that makes counter==BEATS goes to LOAD.
- LOAD (1 cycle):
  - scan_in_bus <= shreg; scan_in_load=1 that cycle; counter cleared; return to IDLE.
  - Latency: last beat accepted at cycle N, scan_in_bus valid and scan_in_load high at N+1.
- CAPTURE (1 cycle):
  - capreg <= scan_out_bus; counter=0; go to SHIFT_OUT.
- SHIFT_OUT:
  - so_valid=1; so_data = capreg[DATA_W-1 -: SER_W].
  - On so_ready: capreg shifts left by SER_W, zero-filled; counter++.
  - so_valid low-stall hold: so_data stable while so_ready=0.
  - The handshake at counter==BEATS-1 returns to IDLE; so_valid drops the next cycle.
- Abort:
  - Enable of the active direction deasserts mid SHIFT_IN or SHIFT_OUT: next cycle FSM=IDLE, counter=0, partial data discarded.
  - scan_in_bus is unchanged and no scan_in_load pulse is issued.
  - LOAD and CAPTURE always complete.
- Conflict:
  - enable_scan_in & enable_scan_out both high in any cycle: conflict<=1 (sticky until reset).
  - If busy, abort to IDLE; no transfer starts while both are high.
- si_ready=0 in LOAD, CAPTURE, SHIFT_OUT; so_valid=0 outside SHIFT_OUT.
- Reset asserted mid-operation: everything returns to reset values asynchronously; no scan_in_load pulse.
- busy=1 in every state except IDLE.

Test Plan:
- SER_W=1, enable_scan_in=1, stream 128 beats of 128'h000102030405060708090A0B0C0D0E0F MSB-first with si_valid always high -> scan_in_load pulses once, exactly 1 cycle after beat 128; scan_in_bus equals the word; busy=0 the following cycle.
- Same stream with si_valid dropped for 5 cycles at beats 10 and 100 -> identical scan_in_bus; pulse delayed by 10 cycles; no extra beats accepted.
- scan_out_bus=128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, enable_scan_out=1, capture pulse, so_ready toggling 1/0 -> 128 beats out reproduce the word MSB-first; so_valid low after the last handshake.
- enable_scan_in dropped after beat 64 of a shift-in -> FSM returns to IDLE; scan_in_bus keeps its previous value (0 after reset); no scan_in_load; a following full 128-beat load succeeds.
- Both enables high during SHIFT_OUT -> conflict=1 next cycle; shift-out aborted; conflict remains 1 until reset_n pulsed high.
- reset_n pulsed high for a fraction of a clock at beat 50 of a shift-in -> all outputs 0 immediately, no clock edge required; FSM=IDLE after release.
